// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a captured 1..PAT_W bit pattern out MSB-first,
// each bit held div+1 clocks, with one-shot/repeat modes and a 7-segment bit countdown.
module seq_pattern_tx #(
  parameter int PAT_W = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [3:0]       len,
  input  logic [DIV_W-1:0] div,
  input  logic             rpt,
  input  logic             abort,
  output logic             x_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [7:0]       seg
);

  localparam logic [3:0] MAX_LEN = 4'(PAT_W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             go_q, go_d;
  logic [15:0]      pat_q, pat_d;
  logic [3:0]       len_q, len_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             rpt_q, rpt_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       rem_q, rem_d;
  logic             x_q, x_d;
  logic             bv_q, bv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [6:0]       seg_q, seg_d;

  logic [3:0]       len_eff;
  logic [3:0]       top_idx;
  logic [3:0]       nxt_idx;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Reset polarity is inherited from the existing codebase: high = in reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      pat_q   <= '0;
      len_q   <= '0;
      div_q   <= '0;
      rpt_q   <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      x_q     <= 1'b0;
      bv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      seg_q   <= 7'h3F;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      div_q   <= div_d;
      rpt_q   <= rpt_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      x_q     <= x_d;
      bv_q    <= bv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      seg_q   <= seg_d;
    end
  end

  always_comb begin
    len_eff = ((len == 4'd0) || (len > MAX_LEN)) ? MAX_LEN : len;
    top_idx = len_q - 4'd1;
    nxt_idx = idx_q - 4'd1;

    state_d = state_q;
    go_d    = go_q;
    pat_d   = pat_q;
    len_d   = len_q;
    div_d   = div_q;
    rpt_d   = rpt_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    x_d     = x_q;
    busy_d  = busy_q;
    bv_d    = 1'b0;
    done_d  = 1'b0;

    if (ena) begin
      if (abort) begin
        state_d = S_IDLE;
        go_d    = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        rem_d   = '0;
        x_d     = 1'b0;
        busy_d  = 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // Capture cycle and first-bit cycle are split by go_q so the
            // first bit appears one edge after start is sampled.
            if (go_q) begin
              go_d    = 1'b0;
              state_d = S_SHIFT;
              idx_d   = top_idx;
              cnt_d   = div_q;
              x_d     = pat_q[top_idx];
              bv_d    = 1'b1;
              busy_d  = 1'b1;
            end else if (start) begin
              go_d  = 1'b1;
              pat_d = 16'(pattern);
              len_d = len_eff;
              div_d = div;
              rpt_d = rpt;
              rem_d = len_eff;
            end
          end
          S_SHIFT: begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - 1'b1;
            end else if (idx_q == 4'd0) begin
              if (rpt_q) begin
                idx_d = top_idx;
                cnt_d = div_q;
                rem_d = len_q;
                x_d   = pat_q[top_idx];
                bv_d  = 1'b1;
              end else begin
                state_d = S_DONE;
                rem_d   = '0;
                x_d     = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end else begin
              idx_d = nxt_idx;
              cnt_d = div_q;
              rem_d = rem_q - 4'd1;
              x_d   = pat_q[nxt_idx];
              bv_d  = 1'b1;
            end
          end
          default: begin
            state_d = S_IDLE;
          end
        endcase
      end
    end

    seg_d = hex7(rem_d);
  end

  assign x_out     = x_q;
  assign bit_valid = bv_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign seg       = {busy_q, seg_q};

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: queue-based behavioural model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_seq_pattern_tx;
  localparam int PAT_W = 8;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena, start, rpt, abort;
  logic [PAT_W-1:0] pattern;
  logic [3:0]       len;
  logic [DIV_W-1:0] div;
  logic             x_out, bit_valid, busy, done;
  logic [7:0]       seg;

  int total = 0;
  int bad   = 0;

  seq_pattern_tx #(.PAT_W(PAT_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .pattern(pattern),
    .len(len), .div(div), .rpt(rpt), .abort(abort), .x_out(x_out),
    .bit_valid(bit_valid), .busy(busy), .done(done), .seg(seg)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 captured, 2 sending, 3 done
  bit   full_q[$];
  bit   cur_q[$];
  int   phase, hold, per, lm, ex_r;
  bit   rptm;
  logic ex_x, ex_bv, ex_busy, ex_done;

  task automatic present();
    ex_x    = cur_q[0];
    ex_bv   = 1'b1;
    ex_busy = 1'b1;
    hold    = per;
    ex_r    = cur_q.size();
  endtask

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      phase = 0; full_q = {}; cur_q = {}; hold = 0; per = 1; lm = 0; rptm = 0;
      ex_x = 0; ex_bv = 0; ex_busy = 0; ex_done = 0; ex_r = 0;
    end else begin
      ex_bv = 0;
      ex_done = 0;
      if (ena) begin
        if (abort) begin
          phase = 0; cur_q = {}; ex_x = 0; ex_busy = 0; ex_r = 0;
        end else begin
          case (phase)
            0: if (start) begin
              lm = (len == 0 || int'(len) > PAT_W) ? PAT_W : int'(len);
              full_q = {};
              for (int i = lm - 1; i >= 0; i--) full_q.push_back(pattern[i]);
              per  = int'(div) + 1;
              rptm = rpt;
              ex_r = lm;
              phase = 1;
            end
            1: begin
              cur_q = full_q;
              present();
              phase = 2;
            end
            2: begin
              hold--;
              if (hold == 0) begin
                void'(cur_q.pop_front());
                if (cur_q.size() == 0) begin
                  if (rptm) begin
                    cur_q = full_q;
                    present();
                  end else begin
                    phase = 3; ex_x = 0; ex_busy = 0; ex_done = 1; ex_r = 0;
                  end
                end else begin
                  present();
                end
              end
            end
            default: phase = 0;
          endcase
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("m_x_out", int'(x_out), int'(ex_x));
      chk("m_bit_valid", int'(bit_valid), int'(ex_bv));
      chk("m_busy", int'(busy), int'(ex_busy));
      chk("m_done", int'(done), int'(ex_done));
      chk("m_seg", int'(seg), int'({ex_busy, hex_tab[ex_r]}));
    end
  end

  // ---------------- directed stimulus ----------------
  logic       xs  [64];
  logic       bvs [64];
  logic       dns [64];
  logic       bss [64];
  logic [7:0] sgs [64];

  task automatic sample(input int e);
    @(negedge clk);
    xs[e] = x_out; bvs[e] = bit_valid; dns[e] = done; bss[e] = busy; sgs[e] = seg;
  endtask

  task automatic launch(input logic [7:0] p, input logic [3:0] l, input logic [7:0] d,
                        input logic r);
    @(negedge clk);
    pattern = p; len = l; div = d; rpt = r; start = 1'b1; abort = 1'b0; ena = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic int first_done(input int n);
    for (int e = 1; e <= n; e++) if (dns[e]) return e;
    return -1;
  endfunction

  function automatic int count_bv(input int n);
    int c = 0;
    for (int e = 1; e <= n; e++) if (bvs[e]) c++;
    return c;
  endfunction

  function automatic int bits_at_bv(input int n);
    int v = 0;
    for (int e = 1; e <= n; e++) if (bvs[e]) v = (v << 1) | int'(xs[e]);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; ena = 1'b0; start = 1'b0; rpt = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; div = '0;
    repeat (2) @(negedge clk);
    chk("rst_x", int'(x_out), 0);
    chk("rst_bv", int'(bit_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_seg", int'(seg), 'h3F);
    rst_n = 1'b0;
    ena = 1'b1;

    // 1: basic one-shot
    launch(8'h04, 4'd3, 8'd0, 1'b0);
    for (int e = 1; e <= 6; e++) sample(e);
    chk("t1_x1", int'(xs[1]), 1);
    chk("t1_x2", int'(xs[2]), 0);
    chk("t1_bits", bits_at_bv(6), 'b100);
    chk("t1_nbv", count_bv(6), 3);
    chk("t1_busy3", int'(bss[3]), 1);
    chk("t1_done", first_done(6), 4);
    chk("t1_x4", int'(xs[4]), 0);
    chk("t1_seg1", int'(sgs[1]), 'hCF);
    chk("t1_seg2", int'(sgs[2]), 'hDB);
    chk("t1_seg3", int'(sgs[3]), 'h86);
    chk("t1_seg4", int'(sgs[4]), 'h3F);

    // 2: divider, len 0 means full width
    launch(8'hA5, 4'd0, 8'd2, 1'b0);
    for (int e = 1; e <= 28; e++) sample(e);
    chk("t2_bits", bits_at_bv(28), 'hA5);
    chk("t2_nbv", count_bv(28), 8);
    chk("t2_x3", int'(xs[3]), 1);
    chk("t2_x4", int'(xs[4]), 0);
    chk("t2_bv4", int'(bvs[4]), 1);
    chk("t2_done", first_done(28), 25);

    // 3: repeat with no gap, then abort on the second bit
    launch(8'h02, 4'd2, 8'd0, 1'b1);
    for (int e = 1; e <= 10; e++) begin
      sample(e);
      abort = (e == 6);
    end
    chk("t3_bits", bits_at_bv(6), 'b101010);
    chk("t3_x7", int'(xs[7]), 0);
    chk("t3_busy7", int'(bss[7]), 0);
    chk("t3_bv7", int'(bvs[7]), 0);
    chk("t3_nodone", first_done(10), -1);
    chk("t3_busy10", int'(bss[10]), 0);

    // 4: start and pattern/len changes after capture are ignored
    launch(8'h0B, 4'd4, 8'd1, 1'b0);
    for (int e = 1; e <= 13; e++) begin
      sample(e);
      if (e == 1) begin pattern = 8'hFF; len = 4'd2; div = 8'd0; end
      start = (e == 2) || (e == 9);
    end
    chk("t4_bits", bits_at_bv(13), 'b1011);
    chk("t4_nbv", count_bv(13), 4);
    chk("t4_done", first_done(13), 9);
    chk("t4_busy11", int'(bss[11]), 0);
    chk("t4_busy12", int'(bss[12]), 0);

    // 5: enable freeze mid-bit
    launch(8'h01, 4'd2, 8'd3, 1'b0);
    for (int e = 1; e <= 16; e++) begin
      sample(e);
      if (e == 2) ena = 1'b0;
      if (e == 7) ena = 1'b1;
    end
    chk("t5_nbv", count_bv(16), 2);
    chk("t5_x9", int'(xs[9]), 0);
    chk("t5_x10", int'(xs[10]), 1);
    chk("t5_bv10", int'(bvs[10]), 1);
    chk("t5_seg5", int'(sgs[5]), 'hDB);
    chk("t5_done", first_done(16), 14);

    // 6: asynchronous reset mid-shift, then a clean transmission
    launch(8'hFF, 4'd8, 8'd1, 1'b0);
    for (int e = 1; e <= 3; e++) sample(e);
    #2 rst_n = 1'b1;
    #1;
    chk("t6_x", int'(x_out), 0);
    chk("t6_bv", int'(bit_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_seg", int'(seg), 'h3F);
    @(negedge clk);
    rst_n = 1'b0;
    launch(8'h06, 4'd3, 8'd0, 1'b0);
    for (int e = 1; e <= 6; e++) sample(e);
    chk("t6_bits", bits_at_bv(6), 'b110);
    chk("t6_seg1", int'(sgs[1]), 'hCF);
    chk("t6_done", first_done(6), 4);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the stimulus end of the team's serial sequence detector.
- Captures a programmable bit pattern of 1..PAT_W bits and shifts it out MSB-first on a single line, holding each bit for a programmable number of clocks.
- Supports one-shot and continuous-repeat modes and can be aborted at any time.
- Drives a 7-segment display with the number of bits still to send, plus a busy decimal point.

Parameters:
- PAT_W, 8: maximum pattern length in bits; range 1..15.
- DIV_W, 8: width of the bit-period divider field.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- ena  input  1  block enable; when low, all state and outputs hold.
- start  input  1  request transmission; sampled only in IDLE.
- pattern  input  PAT_W  bits to send; sent from bit len-1 down to bit 0.
- len  input  4  number of bits to send; 0 or >PAT_W is treated as PAT_W.
- div  input  DIV_W  bit period minus one (each bit lasts div+1 clocks).
- rpt  input  1  repeat mode: after the last bit, restart with no gap.
- abort  input  1  synchronous stop.
- x_out  output  1  serial data.
- bit_valid  output  1  one-cycle strobe on the first clock of each presented bit.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when a one-shot transmission completes.
- seg  output  8  seg[6:0] = {g,f,e,d,c,b,a}, active high; seg[7] = decimal point = busy.

Behaviour:
- Reset: rst_n, asynchronous, active-high; clock clk. Reset is applied when rst_n=1.
- Reset values: state IDLE, x_out=0, bit_valid=0, busy=0, done=0, all internal registers 0, seg shows "0" (8'b0011_1111).
- All outputs are registered.
- ena=0: nothing updates, including the divider counter. Strobes (bit_valid, done) are forced low while ena=0. start and abort are ignored.

State machine, 3 states:
- IDLE: x_out=0, busy=0. On start=1 and ena=1 at edge k, capture pattern, effective len L, div and rpt into shadow registers; the inputs may then change freely. At edge k+1 the state becomes SHIFT with x_out=pattern[L-1], bit_valid=1, busy=1.
- SHIFT: each bit is held for div+1 clocks; bit_valid is high on the first clock only. With div=0, bit_valid stays high for every clock of SHIFT.
- After the period of bit 0:
  - Shadow rpt=1: the next clock presents bit L-1 again, with bit_valid=1 and no gap.
  - Shadow rpt=0: go to DONE, x_out=0, busy=0.
- DONE: lasts exactly one clock with done=1, then returns to IDLE.
- start while in SHIFT or DONE: ignored; it is not queued.
- abort=1 (ena=1), any state: next edge enters IDLE with x_out=0, busy=0, bit_valid=0, and no done pulse. abort takes priority over start in the same cycle.
- Remaining-bit count R: loaded with L on capture, decremented at the end of each bit period, reloaded with L on a repeat wrap. Forced to 0 in DONE, IDLE and after abort.
- seg[6:0] shows R as a hex digit 0..F using the standard encoding; seg updates on the same edge as R.
- Divider: the counter is DIV_W bits and counts down from div to 0. div is the all-ones value → period 2^DIV_W clocks, with no overflow.

Test Plan:
1. Basic one-shot: pattern=8'h04, len=3, div=0, rpt=0, start pulse at edge 0 → x_out=1,0,0 at edges 1,2,3; bit_valid=1 at edges 1-3; busy=1 at edges 1-3; done=1 at edge 4 only; x_out=0 at edge 4; seg digits 3,2,1 then 0.
2. Divider: pattern=8'hA5, len=0 (treated as 8), div=2 → bits 1,0,1,0,0,1,0,1, each held 3 clocks (24 clocks total); bit_valid every 3rd clock; done at clock 25.
3. Repeat and abort: pattern=8'h02, len=2, div=0, rpt=1 → x_out=1,0,1,0,… with no gap and no done; abort while the second bit is shown → IDLE next edge, x_out=0, busy=0, no done pulse.
4. Ignored inputs: start pulsed mid-transmission, and pattern/len changed after capture → output sequence unchanged, no restart.
5. Enable freeze: deassert ena for 5 clocks mid-bit with div=3 → x_out, seg and the counter hold; bit resumes with its remaining clocks, total period still 4 enabled clocks.
6. Reset: assert rst_n=1 asynchronously mid-SHIFT → all outputs go to reset values immediately; release, then start → a clean transmission from the first bit.
